sram_stream_fifo: RTL and testbench

SRAM_STREAM_FIFO -- requirements
Module: sram_stream_fifo

---
 rtl/sram_dualport.sv | 28 ++
 rtl/sram_stream_fifo.sv | 75 +++++++
 tb/tb_sram_stream_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_dualport.sv
// Simple dual-port SRAM: one write port and one read port with a registered read output.
// The array and the read register have no reset; contents are undefined until written.
module sram_dualport #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              ren_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wen_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (ren_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/sram_stream_fifo.sv
// Valid/ready stream FIFO built on a registered-read SRAM. The SRAM read register is the
// output stage, so the FIFO holds up to DEPTH words in the array plus one on the output.
module sram_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          up_valid_i,
    output logic                          up_ready_o,
    input  logic [WIDTH-1:0]              up_data_i,
    output logic                          down_valid_o,
    input  logic                          down_ready_i,
    output logic [WIDTH-1:0]              down_data_o,
    output logic [$clog2(DEPTH+2)-1:0]    count_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 2);

    // Handshakes are transfers: a word moves on a rising edge only when valid and ready
    // are both high; valid never depends on ready, and up_ready_o depends only on state.
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [CNT_W-1:0]  mem_count;
    logic              wen;
    logic              ren;

    assign up_ready_o = (mem_count != CNT_W'(DEPTH));
    assign wen        = up_valid_i & up_ready_o;
    // Reads only target committed entries, so a same-cycle write never aliases the read.
    assign ren        = (mem_count != '0) & (~down_valid_o | down_ready_i);
    assign count_o    = mem_count + {{(CNT_W-1){1'b0}}, down_valid_o};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr         <= '0;
            rptr         <= '0;
            mem_count    <= '0;
            down_valid_o <= 1'b0;
        end else begin
            if (wen) begin
                wptr <= (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + ADDR_W'(1);
            end
            if (ren) begin
                rptr <= (rptr == ADDR_W'(DEPTH - 1)) ? '0 : rptr + ADDR_W'(1);
            end
            case ({wen, ren})
                2'b10:   mem_count <= mem_count + CNT_W'(1);
                2'b01:   mem_count <= mem_count - CNT_W'(1);
                default: mem_count <= mem_count;
            endcase
            if (ren) begin
                down_valid_o <= 1'b1;
            end else if (down_ready_i) begin
                down_valid_o <= 1'b0;
            end
        end
    end

    sram_dualport #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk_i   (clk_i),
        .wen_i   (wen),
        .waddr_i (wptr),
        .wdata_i (up_data_i),
        .ren_i   (ren),
        .raddr_i (rptr),
        .rdata_o (down_data_o)
    );

endmodule

// File: tb/tb_sram_stream_fifo.sv
// Directed bench for sram_stream_fifo (WIDTH=8, DEPTH=8): vector table plus
// streaming, backpressure and mid-stream reset sequences.
module tb_sram_stream_fifo;

    logic       clk;
    logic       rst_n;
    logic       up_valid;
    logic       up_ready;
    logic [7:0] up_data;
    logic       down_valid;
    logic       down_ready;
    logic [7:0] down_data;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       uv;
        logic [7:0] d;
        logic       dr;
        logic       er;
        logic       ev;
        logic [3:0] ec;
        logic       chk;
        logic [7:0] ed;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    sram_stream_fifo #(.WIDTH(8), .DEPTH(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .up_valid_i   (up_valid),
        .up_ready_o   (up_ready),
        .up_data_i    (up_data),
        .down_valid_o (down_valid),
        .down_ready_i (down_ready),
        .down_data_o  (down_data),
        .count_o      (count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic uv, input logic [7:0] d, input logic dr, input logic er,
                       input logic ev, input logic [3:0] ec, input logic chk, input logic [7:0] ed);
        vec_t v;
        v.uv = uv; v.d = d; v.dr = dr; v.er = er; v.ev = ev; v.ec = ec; v.chk = chk; v.ed = ed;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] held;
        logic       stalled;
        int         received;
        int         cyc;
        int         sent;

        rst_n = 1'b0; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
        #1;
        check("reset_up_ready", int'(up_ready), 1);
        check("reset_down_valid", int'(down_valid), 0);
        check("reset_count", int'(count), 0);
        tick(); tick();
        rst_n = 1'b1;

        // single word: accepted, visible one edge later, consumed
        add(1, 8'hA5, 1, 1, 0, 1, 0, 8'h00);
        add(0, 8'h00, 1, 1, 1, 1, 1, 8'hA5);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        // fill with downstream stalled: 8 in SRAM plus 1 on output
        for (int k = 0; k < 9; k++)
            add(1, 8'(k), 0, (k < 8), (k >= 1), 4'(k + 1), (k >= 1), 8'h00);
        add(1, 8'h09, 0, 0, 1, 9, 1, 8'h00);
        // full plus read: refused this edge, accepted the next
        add(1, 8'h99, 1, 1, 1, 8, 1, 8'h01);
        add(1, 8'h99, 1, 1, 1, 8, 1, 8'h02);
        for (int e = 3; e <= 8; e++)
            add(0, 8'h00, 1, 1, 1, 4'(10 - e), 1, 8'(e));
        add(0, 8'h00, 1, 1, 1, 1, 1, 8'h99);
        add(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            up_valid = vecs[i].uv; up_data = vecs[i].d; down_ready = vecs[i].dr;
            tick();
            check($sformatf("vec%0d_up_ready", i), int'(up_ready), int'(vecs[i].er));
            check($sformatf("vec%0d_down_valid", i), int'(down_valid), int'(vecs[i].ev));
            check($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].ec));
            if (vecs[i].chk)
                check($sformatf("vec%0d_data", i), int'(down_data), int'(vecs[i].ed));
        end

        // streaming: 100 words, both sides always willing
        sent = 0; received = 0; cyc = 0;
        while (received < 100 && cyc < 300) begin
            up_valid = (sent < 100); up_data = 8'(sent + 8'h10); down_ready = 1'b1;
            if (down_valid) begin
                if (exp_q.size() == 0) check("stream_underflow", 1, 0);
                else check($sformatf("stream_word%0d", received), int'(down_data), int'(exp_q.pop_front()));
                received++;
            end
            if (up_valid && up_ready) begin
                exp_q.push_back(up_data);
                sent++;
            end
            tick();
            cyc++;
        end
        check("stream_received", received, 100);
        check("stream_cycles", cyc, 102);
        up_valid = 1'b0;
        tick();
        check("stream_empty_count", int'(count), 0);

        // backpressure: 1,0,0,1 then random ready, random offers
        exp_q.delete();
        stalled = 1'b0; held = '0;
        for (int c = 0; c < 300; c++) begin
            logic [3:0] pat;
            pat = 4'b1001;
            if (c < 4) down_ready = pat[3 - c];
            else down_ready = 1'(($urandom_range(0, 2) != 0) && (c < 260));
            up_valid = 1'((c < 240) && ($urandom_range(0, 1) == 1));
            up_data = 8'($urandom_range(0, 255));
            if (stalled) begin
                check("bp_hold_valid", int'(down_valid), 1);
                check("bp_hold_data", int'(down_data), int'(held));
            end
            if (down_valid && down_ready) begin
                if (exp_q.size() == 0) check("bp_underflow", 1, 0);
                else check("bp_word", int'(down_data), int'(exp_q.pop_front()));
            end
            if (up_valid && up_ready) exp_q.push_back(up_data);
            stalled = down_valid && !down_ready;
            held = down_data;
            tick();
        end
        up_valid = 1'b0; down_ready = 1'b1;
        cyc = 0;
        while ((down_valid || exp_q.size() != 0) && cyc < 50) begin
            if (down_valid) begin
                if (exp_q.size() == 0) check("bp_drain_underflow", 1, 0);
                else check("bp_drain_word", int'(down_data), int'(exp_q.pop_front()));
            end
            tick();
            cyc++;
        end
        check("bp_drain_left", exp_q.size(), 0);
        check("bp_drain_count", int'(count), 0);

        // reset mid-stream with five words held
        down_ready = 1'b0; up_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            up_data = 8'(8'h50 + k);
            tick();
        end
        up_valid = 1'b0;
        check("pre_reset_count", int'(count), 5);
        rst_n = 1'b0;
        #1;
        check("midreset_down_valid", int'(down_valid), 0);
        check("midreset_count", int'(count), 0);
        check("midreset_up_ready", int'(up_ready), 1);
        tick();
        rst_n = 1'b1;
        up_valid = 1'b1; up_data = 8'h3C; down_ready = 1'b1;
        tick();
        up_valid = 1'b0;
        check("post_reset_first_accept", int'(count), 1);
        cyc = 0;
        while (!down_valid && cyc < 5) begin
            tick();
            cyc++;
        end
        check("post_reset_valid", int'(down_valid), 1);
        check("post_reset_data", int'(down_data), 8'h3C);
        tick();
        check("post_reset_drained", int'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
